// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
package apb_arb_pkg;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               idx_o
);

    always_comb begin
        idx_o   = 1'b0;
        grant_o = '0;
        unique case (valid_i)
            2'b01:   idx_o = 1'b0;
            2'b10:   idx_o = 1'b1;
            2'b11:   idx_o = ~last_i;
            default: idx_o = 1'b0;
        endcase
        if (valid_i != '0) begin
            grant_o = 2'b01 << idx_o;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters (round-robin, SETUP->ACCESS).
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int BUS_WIDTH      = 64,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int STRB_WIDTH     = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // Request side: a request is taken in the cycle req_valid_i[i] && req_ready_o[i];
    // the requester holds valid and payload until then. rsp_valid_o is a one-cycle pulse.
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [BUS_WIDTH-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    input  logic                          slv_busy_i,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    output logic [BUS_WIDTH-1:0]          pwdata_o,
    output logic [STRB_WIDTH-1:0]         pstrb_o,
    input  logic [BUS_WIDTH-1:0]          prdata_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    output logic [1:0]                    state_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    apb_state_e              state_q, state_d;
    logic                    last_q;
    logic [NUM_REQ-1:0]      grant;
    logic                    gidx;
    logic                    accept;
    logic                    done;
    logic                    timeout;
    logic                    cap_idx_q;
    logic                    cap_write_q;
    logic [ADDR_WIDTH-1:0]   cap_addr_q;
    logic [BUS_WIDTH-1:0]    cap_wdata_q;
    logic [STRB_WIDTH-1:0]   cap_strb_q;
    logic [BUS_WIDTH-1:0]    rdata_q;
    logic                    err_q;

    rr_arbiter2 u_rr (
        .valid_i (req_valid_i),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_q <= '0;
        end else if (state_q == ACCESS && !pready_i) begin
            tmo_q <= tmo_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        done        = 1'b0;
        timeout     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((req_valid_i != '0) && !slv_busy_i) begin
                    req_ready_o = grant;
                    accept      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LIMIT) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cap_idx_q   <= 1'b0;
            cap_write_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_strb_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q      <= gidx;
                cap_idx_q   <= gidx;
                cap_write_q <= req_write_i[gidx];
                cap_addr_q  <= gidx ? req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                    : req_addr_i[0 +: ADDR_WIDTH];
                cap_wdata_q <= gidx ? req_wdata_i[BUS_WIDTH +: BUS_WIDTH]
                                    : req_wdata_i[0 +: BUS_WIDTH];
                // Reads never drive strobes onto the bus.
                if (req_write_i[gidx]) begin
                    cap_strb_q <= gidx ? req_strb_i[STRB_WIDTH +: STRB_WIDTH]
                                       : req_strb_i[0 +: STRB_WIDTH];
                end else begin
                    cap_strb_q <= '0;
                end
            end
            if (done) begin
                rdata_q <= cap_write_q ? '0 : prdata_i;
                err_q   <= pslverr_i;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign pwrite_o    = cap_write_q;
    assign paddr_o     = cap_addr_q;
    assign pwdata_o    = cap_wdata_q;
    assign pstrb_o     = cap_strb_q;
    assign rsp_valid_o = (state_q == RESP) ? (2'b01 << cap_idx_q) : 2'b00;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: random requesters, APB slave model, response scoreboard.
module tb_apb_master_arbiter;

    localparam int AW   = 32;
    localparam int BW   = 64;
    localparam int SW   = 2;
    localparam int TMO  = 16;
    localparam int EW   = 98;   // {id, rdata, err, cycle}
    localparam int QW   = 132;  // {id, write, addr, wdata, strb, cycle}

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            vld    [2];
    logic            wr     [2];
    logic [AW-1:0]   addr_a [2];
    logic [BW-1:0]   wdat_a [2];
    logic [SW-1:0]   strb_a [2];
    logic [1:0]      req_ready, rsp_valid;
    logic [BW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            slv_busy = 1'b0;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [BW-1:0]   pwdata;
    logic [SW-1:0]   pstrb;
    logic [BW-1:0]   prdata = '0;
    logic            pready = 1'b0, pslverr = 1'b0;
    logic [1:0]      dbg_state;

    logic [EW-1:0]   exp_q [$];
    logic [QW-1:0]   apb_q [$];
    int              grant_log [$];
    int              grant_cyc [$];
    int              n_checks = 0, n_errors = 0;
    int              cyc = 0;
    int              last_m = 1, last_acc_cyc = -100;
    int              force_wait = -1, force_err = -1;
    bit              use_fixed = 0;
    logic [BW-1:0]   fixed_data = '0;
    int              last_acc_len = 0;
    bit              stop_busy = 0;

    apb_master_arbiter #(.DATA_WIDTH(32), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i ({vld[1], vld[0]}),
        .req_write_i ({wr[1], wr[0]}),
        .req_addr_i  ({addr_a[1], addr_a[0]}),
        .req_wdata_i ({wdat_a[1], wdat_a[0]}),
        .req_strb_i  ({strb_a[1], strb_a[0]}),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .slv_busy_i  (slv_busy),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr),
        .state_o     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        apb_q.delete();
        last_m       = 1;
        last_acc_cyc = -100;
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the rising edge following accept.
    task automatic issue(input int id, input bit w, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic [SW-1:0] s);
        int t;
        vld[id] = 1'b1; wr[id] = w; addr_a[id] = a; wdat_a[id] = d; strb_a[id] = s;
        t = 0;
        forever begin
            @(negedge clk_i);
            if (req_ready[id]) break;
            t++;
            if (t > 300) begin
                check($sformatf("ready_timeout_req%0d", id), 64'(req_ready), 64'(2'b01 << id));
                break;
            end
        end
        @(posedge clk_i); #1;
        vld[id] = 1'b0;
        addr_a[id] = $urandom; wdat_a[id] = {$urandom, $urandom}; strb_a[id] = 2'($urandom);
    endtask

    task automatic rand_driver(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk_i);
            #1;
            issue(id, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || apb_q.size() != 0 || psel) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) check("drain_timeout", 64'(t), 64'(0));
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // ---------------- accept monitor: reference arbitration ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && req_ready != 2'b00) begin
                int v, eid;
                v   = {vld[1], vld[0]};
                eid = (v == 3) ? (1 - last_m) : ((v == 2) ? 1 : 0);
                check("grant", 64'(req_ready), 64'(2'b01 << eid));
                check("accept_while_busy", 64'(slv_busy), 64'(0));
                if (cyc - last_acc_cyc < 4) check("accept_spacing", 64'(cyc - last_acc_cyc), 64'(4));
                apb_q.push_back({1'(eid), wr[eid], addr_a[eid], wdat_a[eid],
                                 wr[eid] ? strb_a[eid] : 2'b00, 32'(cyc)});
                grant_log.push_back(eid);
                grant_cyc.push_back(cyc);
                last_m = eid;
                last_acc_cyc = cyc;
            end
        end
    end

    // ---------------- APB slave model ----------------
    initial begin
        logic [QW-1:0] cur;
        int            acc_cnt, w;
        bit            in_acc;
        in_acc = 0; acc_cnt = 0; w = 0; cur = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                in_acc = 0; pready = 1'b0;
            end else if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    check("setup_unexpected", 64'(psel), 64'(0));
                end else begin
                    cur = apb_q.pop_front();
                    check("setup_addr",    64'(paddr),  64'(cur[129:98]));
                    check("setup_write",   64'(pwrite), 64'(cur[130]));
                    check("setup_wdata",   pwdata,      cur[97:34]);
                    check("setup_strb",    64'(pstrb),  64'(cur[33:32]));
                    check("setup_latency", 64'(cyc),    64'(int'(cur[31:0]) + 1));
                    in_acc  = 1;
                    acc_cnt = 0;
                    w = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
                end
                pready = 1'b0;
            end else if (psel && penable) begin
                if (!in_acc) begin
                    check("access_unexpected", 64'(penable), 64'(0));
                end else begin
                    acc_cnt++;
                    check("access_addr_stable",  64'(paddr), 64'(cur[129:98]));
                    check("access_wdata_stable", pwdata,     cur[97:34]);
                    if (acc_cnt == w + 1) begin
                        pready  = 1'b1;
                        prdata  = use_fixed ? fixed_data : {$urandom, $urandom};
                        pslverr = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 7) == 0);
                        exp_q.push_back({cur[131], cur[130] ? 64'h0 : prdata, pslverr, 32'(cyc + 1)});
                        last_acc_len = acc_cnt;
                        in_acc = 0;
                    end else begin
                        pready  = 1'b0;
                        prdata  = {$urandom, $urandom};
                        pslverr = 1'($urandom);
`ifdef APB_ARB_TIMEOUT_EN
                        if (acc_cnt == TMO) begin
                            exp_q.push_back({cur[131], 64'h0, 1'b1, 32'(cyc + 1)});
                            last_acc_len = acc_cnt;
                            in_acc = 0;
                        end
`endif
                    end
                end
            end else begin
                pready = 1'b0;
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (rsp_valid != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id",      64'(rsp_valid), 64'(2'b01 << e[97]));
                        check("rsp_rdata",   rsp_rdata,      e[96:33]);
                        check("rsp_err",     64'(rsp_err),   64'(e[32]));
                        check("rsp_latency", 64'(cyc),       64'(e[31:0]));
                        check("rsp_psel",    64'({psel, penable}), 64'(0));
                    end
                end else if (rsp_err) begin
                    check("rsp_err_idle", 64'(rsp_err), 64'(0));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; addr_a[i] = '0; wdat_a[i] = '0; strb_a[i] = '0;
        end
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_apb_ctrl", 64'({psel, penable, pwrite}), 64'(0));
        check("reset_apb_data", 64'(paddr) | pwdata | 64'(pstrb), 64'(0));
        check("reset_rsp",      64'({rsp_valid, rsp_err, req_ready}), 64'(0));
        check("reset_rdata",    rsp_rdata, 64'(0));
        rst_ni = 1'b1;
        reset_model();
        @(posedge clk_i); #1;

        // single read, zero wait
        force_wait = 0; force_err = 0; use_fixed = 1; fixed_data = 64'hDEAD_BEEF_0000_0001;
        issue(0, 1'b0, 32'h1, 64'h1234, 2'b11);
        drain();

        // write with three wait states, then ACCESS length check
        force_wait = 3; use_fixed = 0;
        issue(1, 1'b1, 32'h0, 64'hCAFE_F00D_0BAD_BEEF, 2'b10);
        drain();
        check("write_access_len", 64'(last_acc_len), 64'(4));

        // zero-strobe write is forwarded unchanged
        force_wait = 1;
        issue(1, 1'b1, 32'h40, 64'h5555_AAAA_5555_AAAA, 2'b00);
        drain();

        // contention: requester 1 was served last, so order is 0,1,0,1 every 4 cycles
        force_wait = 0;
        grant_log.delete(); grant_cyc.delete();
        fork
            begin
                issue(0, 1'b0, 32'h100, 64'h0, 2'b00);
                issue(0, 1'b1, 32'h104, 64'h11, 2'b01);
            end
            begin
                issue(1, 1'b0, 32'h200, 64'h0, 2'b00);
                issue(1, 1'b1, 32'h204, 64'h22, 2'b11);
            end
        join
        drain();
        check("contention_count", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("contention_order%0d", k), 64'(grant_log[k]), 64'(k % 2));
                if (k > 0) check($sformatf("contention_gap%0d", k), 64'(grant_cyc[k] - grant_cyc[k-1]), 64'(4));
            end
        end

        // busy gating: request pending while slave busy for 5 cycles
        slv_busy = 1'b1;
        fork
            issue(0, 1'b0, 32'h300, 64'h0, 2'b00);
        join_none
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("busy_no_ready", 64'({req_ready, psel}), 64'(0));
        end
        @(posedge clk_i); #1;
        slv_busy = 1'b0;
        @(negedge clk_i);
        check("busy_release_accept", 64'(req_ready), 64'(2'b01));
        wait fork;
        drain();

        // slave error on a read
        force_err = 1; force_wait = 2;
        issue(1, 1'b0, 32'h8, 64'h0, 2'b11);
        drain();
        force_err = -1;

`ifdef APB_ARB_TIMEOUT_EN
        // hung slave: 16 ACCESS cycles then error response with zero data
        force_wait = 1000;
        issue(0, 1'b0, 32'hC, 64'h0, 2'b00);
        drain();
        check("timeout_access_len", 64'(last_acc_len), 64'(TMO));
`endif

        // async reset during ACCESS: bus drops at once, no response afterwards
        force_wait = 1000;
        issue(0, 1'b0, 32'h10, 64'h0, 2'b00);
        repeat (3) @(negedge clk_i);
        check("pre_reset_access", 64'({psel, penable}), 64'(2'b11));
        #2;
        rst_ni = 1'b0;
        #1;
        check("reset_drops_psel", 64'({psel, penable}), 64'(0));
        reset_model();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check("no_rsp_after_reset", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk_i); #1;

        // randomized traffic with random waits, errors and busy
        force_wait = -1; force_err = -1; use_fixed = 0;
        fork
            begin
                fork
                    rand_driver(0, 15);
                    rand_driver(1, 15);
                join
                stop_busy = 1;
            end
            begin
                while (!stop_busy) begin
                    @(posedge clk_i); #1;
                    slv_busy = ($urandom_range(0, 3) == 0);
                end
                slv_busy = 1'b0;
            end
        join
        drain();
        check("scoreboard_empty", 64'(exp_q.size() + apb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB port of the matmul APB slave between two internal requesters (host command path and data loader).
- Each requester issues a simple valid/ready transaction request.
- The block arbitrates round-robin and drives the full APB master sequence (SETUP -> ACCESS).
- It returns read data and error per requester, and guards against a hung slave with a timeout.

Parameters:
- DATA_WIDTH, 32, width of one matrix element; one strobe bit per element.
- BUS_WIDTH, 64, APB data width.
- ADDR_WIDTH, 32, APB address width.
- STRB_WIDTH, BUS_WIDTH/DATA_WIDTH, strobe width (localparam).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready_i (range 2..255).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  request valid, bit i = requester i
- req_write_i  in  2  1=write, 0=read, per requester
- req_addr_i  in  2*ADDR_WIDTH  address; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  2*BUS_WIDTH  write data, sliced likewise
- req_strb_i  in  2*STRB_WIDTH  write strobes, sliced likewise
- req_ready_o  out  2  one-hot accept pulse
- rsp_valid_o  out  2  one-hot response pulse
- rsp_rdata_o  out  BUS_WIDTH  read data, qualified by rsp_valid_o
- rsp_err_o  out  1  error flag, qualified by rsp_valid_o
- slv_busy_i  in  1  slave busy; blocks starting a new transfer
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  BUS_WIDTH  APB write data
- pstrb_o  out  STRB_WIDTH  APB strobes
- prdata_i  in  BUS_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset (async): all outputs 0, state IDLE, rr pointer prefers requester 0, timeout counter 0.
- States: IDLE, SETUP, ACCESS, RESP. Encoding 2 bits, in the package.
- IDLE:
  - Grant is computed combinationally among req_valid_i.
  - Both valid: grant the requester not served last. After reset, requester 0 wins.
  - If any request is valid and slv_busy_i=0: req_ready_o[g]=1 for that cycle; the request is captured into internal registers; next state is SETUP; the rr pointer updates to g.
  - If slv_busy_i=1: no accept, stay in IDLE.
- SETUP (1 cycle):
  - psel_o=1, penable_o=0.
  - paddr_o, pwrite_o and pwdata_o come from the captured request.
  - pstrb_o = captured strobes on write; forced 0 on read.
  - Next state: ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; address, data and control held stable.
  - On pready_i=1: latch rdata (prdata_i on read, 0 on write) and err=pslverr_i; next state RESP.
- RESP (1 cycle):
  - rsp_valid_o[g]=1, rsp_rdata_o and rsp_err_o valid; psel_o=0, penable_o=0.
  - Next state: IDLE.
- Latency: accept at T -> SETUP T+1 -> ACCESS T+2 -> with zero wait states, rsp_valid_o at T+3. Minimum spacing between accepts is 4 cycles.
- Requester obligations and independence:
  - A requester holds valid and payload until it sees req_ready_o.
  - Payload changes after accept have no effect.
  - A req_valid_i drop while in IDLE without an accept is legal.
- Between transfers, APB outputs other than psel_o/penable_o hold their last values.
- rsp_rdata_o holds its last value outside RESP. rsp_err_o is 0 outside RESP.
- A write with all-zero strobes is forwarded unchanged.
- Async reset mid-transfer drops psel_o/penable_o immediately. The in-flight request is lost; no response is issued.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready_i still 0, the next state is RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - A pready_i arriving in the same cycle as the limit wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_arb_pkg holds:
  - state encodings IDLE/SETUP/ACCESS/RESP
  - requester count constant NUM_REQ=2
  - default TIMEOUT_CYCLES
- Sub-module rr_arbiter2: combinational 2-way round-robin grant from valid bits and a registered last-grant bit.

Test Plan:
- Single read, zero wait: requester 0 reads 0x1 (prdata_i=0xDEAD_BEEF_0000_0001, pready_i high during ACCESS).
  -> psel_o at T+1, penable_o at T+2, pstrb_o=0, rsp_valid_o=2'b01 at T+3 with that data and err=0.
- Write with wait states: requester 1 writes 0x0 with strb=2'b10 and pready_i delayed 3 cycles.
  -> penable_o held 4 cycles, pwdata_o stable throughout, rsp_valid_o=2'b10 with err=0.
- Contention: both requesters valid continuously for 4 transfers.
  -> grant order 0,1,0,1, accepts exactly 4 cycles apart.
- Busy gating: slv_busy_i=1 for 5 cycles with a request pending.
  -> no req_ready_o and psel_o=0 during those cycles; accept in the first cycle slv_busy_i=0.
- Slave error: pslverr_i=1 with pready_i on a read.
  -> rsp_err_o=1 on the response pulse. Then assert rst_ni=0 during a subsequent ACCESS -> psel_o=0 immediately and no rsp_valid_o.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready_i never asserted.
  -> rsp_err_o=1 and rsp_rdata_o=0 exactly 16 ACCESS cycles after entry, then IDLE.
